// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg: opcodes, ALU/write-back encodings and decode types. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // ADD is zero so that an all-zero control word is a valid bubble.
  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       alu_src_imm;
    logic       alu_src_pc;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] mem_funct3;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       branch;
    logic       jal;
    logic       jalr;
    logic       illegal;
  } ctrl_t;

  function automatic logic [3:0] alu_decode(input logic [2:0] funct3, input logic alt);
    logic [3:0] op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decompressor.sv
// ---------------------------------------------------------------------------
// decompressor: expands RV32C instructions to RV32I; unsupported -> 0. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decompressor
  import riscv_pkg::*;
(
  input  logic [15:0] c_inst,
  output logic [31:0] inst
);

  logic [15:0] c;
  logic [4:0]  rdp;
  logic [4:0]  rs1p;
  logic [11:0] cj;
  logic [12:0] cb;

  assign c    = c_inst;
  assign rdp  = {2'b01, c[4:2]};
  assign rs1p = {2'b01, c[9:7]};
  assign cj   = {c[12], c[8], c[10:9], c[6], c[7], c[2], c[11], c[5:3], 1'b0};
  assign cb   = {{4{c[12]}}, c[12], c[6:5], c[2], c[11:10], c[4:3], 1'b0};

  always_comb begin
    inst = 32'h0;
    case (c[1:0])
      2'b00: begin
        case (c[15:13])
          3'b000: if (c[12:5] != 8'h0)
                    inst = {2'b00, c[10:7], c[12:11], c[5], c[6], 2'b00, 5'd2, 3'b000, rdp, OPC_OP_IMM};
          3'b010: inst = {5'b0, c[5], c[12:10], c[6], 2'b00, rs1p, 3'b010, rdp, OPC_LOAD};
          3'b110: inst = {5'b0, c[5], c[12], rdp, rs1p, 3'b010, c[11:10], c[6], 2'b00, OPC_STORE};
          default: ;
        endcase
      end
      2'b01: begin
        case (c[15:13])
          3'b000: inst = {{7{c[12]}}, c[6:2], c[11:7], 3'b000, c[11:7], OPC_OP_IMM};
          3'b001: inst = {cj[11], cj[10:1], cj[11], {8{cj[11]}}, 5'd1, OPC_JAL};
          3'b010: inst = {{7{c[12]}}, c[6:2], 5'd0, 3'b000, c[11:7], OPC_OP_IMM};
          3'b011: begin
            if (c[11:7] == 5'd2)
              inst = {{3{c[12]}}, c[4:3], c[5], c[2], c[6], 4'b0, 5'd2, 3'b000, 5'd2, OPC_OP_IMM};
            else
              inst = {{15{c[12]}}, c[6:2], c[11:7], OPC_LUI};
          end
          3'b100: begin
            case (c[11:10])
              2'b00: inst = {7'b0000000, c[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM};
              2'b01: inst = {7'b0100000, c[6:2], rs1p, 3'b101, rs1p, OPC_OP_IMM};
              2'b10: inst = {{7{c[12]}}, c[6:2], rs1p, 3'b111, rs1p, OPC_OP_IMM};
              default: begin
                if (!c[12]) begin
                  case (c[6:5])
                    2'b00:   inst = {7'b0100000, rdp, rs1p, 3'b000, rs1p, OPC_OP};
                    2'b01:   inst = {7'b0000000, rdp, rs1p, 3'b100, rs1p, OPC_OP};
                    2'b10:   inst = {7'b0000000, rdp, rs1p, 3'b110, rs1p, OPC_OP};
                    default: inst = {7'b0000000, rdp, rs1p, 3'b111, rs1p, OPC_OP};
                  endcase
                end
              end
            endcase
          end
          3'b101: inst = {cj[11], cj[10:1], cj[11], {8{cj[11]}}, 5'd0, OPC_JAL};
          3'b110: inst = {cb[12], cb[10:5], 5'd0, rs1p, 3'b000, cb[4:1], cb[11], OPC_BRANCH};
          default: inst = {cb[12], cb[10:5], 5'd0, rs1p, 3'b001, cb[4:1], cb[11], OPC_BRANCH};
        endcase
      end
      2'b10: begin
        case (c[15:13])
          3'b000: inst = {7'b0, c[6:2], c[11:7], 3'b001, c[11:7], OPC_OP_IMM};
          3'b010: inst = {4'b0, c[3:2], c[12], c[6:4], 2'b00, 5'd2, 3'b010, c[11:7], OPC_LOAD};
          3'b100: begin
            if (!c[12]) begin
              if (c[6:2] == 5'd0) inst = {12'b0, c[11:7], 3'b000, 5'd0, OPC_JALR};
              else                inst = {7'b0, c[6:2], 5'd0, 3'b000, c[11:7], OPC_OP};
            end else begin
              if (c[11:2] == 10'd0)    inst = 32'h0010_0073;
              else if (c[6:2] == 5'd0) inst = {12'b0, c[11:7], 3'b000, 5'd1, OPC_JALR};
              else                     inst = {7'b0, c[6:2], c[11:7], 3'b000, c[11:7], OPC_OP};
            end
          end
          3'b110: inst = {4'b0, c[8:7], c[12], c[6:2], 5'd2, 3'b010, c[11:9], 2'b00, OPC_STORE};
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/riscv_regfile.sv
// ---------------------------------------------------------------------------
// riscv_regfile: 31x32 register file, 2R/1W, write-to-read bypass. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module riscv_regfile #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hold,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] regs [1:31];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0 && !hold) begin
      regs[waddr] <= wdata;
    end
  end

  // x0 falls out of the loop bounds and reads as zero.
  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    for (int i = 1; i < 32; i++) begin
      if (raddr1 == 5'(i)) rdata1 = regs[i];
      if (raddr2 == 5'(i)) rdata2 = regs[i];
    end
    if (we && waddr == raddr1 && raddr1 != 5'd0) rdata1 = wdata;
    if (we && waddr == raddr2 && raddr2 != 5'd0) rdata2 = wdata;
  end

endmodule

`default_nettype wire

// File: rtl/riscv_id_stage.sv
// ---------------------------------------------------------------------------
// riscv_id_stage: RV32IC decode stage driving the ID/EX register. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module riscv_id_stage
  import riscv_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            flush,
  input  logic [31:0]     inst_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            compressed_i,
  input  logic            wb_wen,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_mem_read,
  input  logic [4:0]      ex_rd,
  output logic            load_use_hazard,
  output logic [XLEN-1:0] pc_ppl,
  output logic [XLEN-1:0] rs1_data_ppl,
  output logic [XLEN-1:0] rs2_data_ppl,
  output logic [31:0]     imm_ppl,
  output logic [4:0]      rs1_ppl,
  output logic [4:0]      rs2_ppl,
  output logic [4:0]      rd_ppl,
  output logic [3:0]      alu_op_ppl,
  output logic            alu_src_imm_ppl,
  output logic            alu_src_pc_ppl,
  output logic            mem_read_ppl,
  output logic            mem_write_ppl,
  output logic [2:0]      mem_funct3_ppl,
  output logic            reg_write_ppl,
  output logic [1:0]      wb_sel_ppl,
  output logic            branch_ppl,
  output logic            jal_ppl,
  output logic            jalr_ppl,
  output logic            compressed_ppl,
  output logic            illegal_ppl
);

  logic [31:0]     expanded;
  logic [31:0]     inst;
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [4:0]      rd;
  logic [31:0]     imm;
  logic            rs1_used;
  logic            rs2_used;
  ctrl_t           ctrl;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  decompressor u_decompressor (
    .c_inst (inst_i[15:0]),
    .inst   (expanded)
  );

  assign inst   = compressed_i ? expanded : inst_i;
  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign rs1    = inst[19:15];
  assign rs2    = inst[24:20];
  assign rd     = ctrl.reg_write ? inst[11:7] : 5'd0;

  always_comb begin
    ctrl     = '0;
    imm      = '0;
    rs1_used = 1'b0;
    rs2_used = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.alu_op      = ALU_PASS_B;
        imm              = {inst[31:12], 12'b0};
      end
      OPC_AUIPC: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.alu_src_pc  = 1'b1;
        imm              = {inst[31:12], 12'b0};
      end
      OPC_JAL: begin
        ctrl.reg_write   = 1'b1;
        ctrl.jal         = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.alu_src_pc  = 1'b1;
        ctrl.wb_sel      = WB_PC;
        imm              = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OPC_JALR: begin
        ctrl.reg_write   = 1'b1;
        ctrl.jalr        = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.alu_src_pc  = 1'b1;
        ctrl.wb_sel      = WB_PC;
        imm              = {{20{inst[31]}}, inst[31:20]};
        rs1_used         = 1'b1;
      end
      OPC_BRANCH: begin
        // funct3 rides along in mem_funct3 so EX can tell the branch condition.
        ctrl.branch      = 1'b1;
        ctrl.mem_funct3  = funct3;
        ctrl.alu_op      = (funct3[2:1] == 2'b00) ? ALU_SUB :
                           (funct3[1] ? ALU_SLTU : ALU_SLT);
        imm              = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
      end
      OPC_LOAD: begin
        ctrl.reg_write   = 1'b1;
        ctrl.mem_read    = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_funct3  = funct3;
        ctrl.wb_sel      = WB_MEM;
        imm              = {{20{inst[31]}}, inst[31:20]};
        rs1_used         = 1'b1;
      end
      OPC_STORE: begin
        ctrl.mem_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.mem_funct3  = funct3;
        imm              = {{20{inst[31]}}, inst[31:25], inst[11:7]};
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
      end
      OPC_OP_IMM: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_src_imm = 1'b1;
        ctrl.alu_op      = alu_decode(funct3, inst[30] && funct3 == 3'b101);
        imm              = {{20{inst[31]}}, inst[31:20]};
        rs1_used         = 1'b1;
      end
      OPC_OP: begin
        ctrl.reg_write   = 1'b1;
        ctrl.alu_op      = alu_decode(funct3, inst[30]);
        rs1_used         = 1'b1;
        rs2_used         = 1'b1;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

  riscv_regfile #(.XLEN(XLEN)) u_regfile (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold   (stall),
    .we     (wb_wen),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  assign load_use_hazard = !flush && ex_mem_read && ex_rd != 5'd0 &&
                           ((rs1_used && ex_rd == rs1) || (rs2_used && ex_rd == rs2));

  ctrl_t ctrl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q         <= '0;
      pc_ppl         <= RESET_PC[XLEN-1:0];
      rs1_data_ppl   <= '0;
      rs2_data_ppl   <= '0;
      imm_ppl        <= '0;
      rs1_ppl        <= '0;
      rs2_ppl        <= '0;
      rd_ppl         <= '0;
      compressed_ppl <= 1'b0;
    end else if (!stall) begin
      pc_ppl <= pc_i;
      if (flush || load_use_hazard) begin
        ctrl_q         <= '0;
        rs1_data_ppl   <= '0;
        rs2_data_ppl   <= '0;
        imm_ppl        <= '0;
        rs1_ppl        <= '0;
        rs2_ppl        <= '0;
        rd_ppl         <= '0;
        compressed_ppl <= 1'b0;
      end else begin
        ctrl_q         <= ctrl;
        rs1_data_ppl   <= rs1_data;
        rs2_data_ppl   <= rs2_data;
        imm_ppl        <= imm;
        rs1_ppl        <= rs1;
        rs2_ppl        <= rs2;
        rd_ppl         <= rd;
        compressed_ppl <= compressed_i;
      end
    end
  end

  assign alu_op_ppl      = ctrl_q.alu_op;
  assign alu_src_imm_ppl = ctrl_q.alu_src_imm;
  assign alu_src_pc_ppl  = ctrl_q.alu_src_pc;
  assign mem_read_ppl    = ctrl_q.mem_read;
  assign mem_write_ppl   = ctrl_q.mem_write;
  assign mem_funct3_ppl  = ctrl_q.mem_funct3;
  assign reg_write_ppl   = ctrl_q.reg_write;
  assign wb_sel_ppl      = ctrl_q.wb_sel;
  assign branch_ppl      = ctrl_q.branch;
  assign jal_ppl         = ctrl_q.jal;
  assign jalr_ppl        = ctrl_q.jalr;
  assign illegal_ppl     = ctrl_q.illegal;

endmodule

`default_nettype wire

// File: tb/tb_riscv_id_stage.sv
// ---------------------------------------------------------------------------
// tb_riscv_id_stage: directed self-checking bench for riscv_id_stage. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_riscv_id_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0080;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, compressed_i, wb_wen, ex_mem_read;
  logic [31:0] inst_i, pc_i, wb_data;
  logic [4:0]  wb_rd, ex_rd;
  logic        load_use_hazard;
  logic [31:0] pc_ppl, rs1_data_ppl, rs2_data_ppl, imm_ppl;
  logic [4:0]  rs1_ppl, rs2_ppl, rd_ppl;
  logic [3:0]  alu_op_ppl;
  logic        alu_src_imm_ppl, alu_src_pc_ppl, mem_read_ppl, mem_write_ppl;
  logic [2:0]  mem_funct3_ppl;
  logic        reg_write_ppl;
  logic [1:0]  wb_sel_ppl;
  logic        branch_ppl, jal_ppl, jalr_ppl, compressed_ppl, illegal_ppl;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  riscv_id_stage #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .stall           (stall),
    .flush           (flush),
    .inst_i          (inst_i),
    .pc_i            (pc_i),
    .compressed_i    (compressed_i),
    .wb_wen          (wb_wen),
    .wb_rd           (wb_rd),
    .wb_data         (wb_data),
    .ex_mem_read     (ex_mem_read),
    .ex_rd           (ex_rd),
    .load_use_hazard (load_use_hazard),
    .pc_ppl          (pc_ppl),
    .rs1_data_ppl    (rs1_data_ppl),
    .rs2_data_ppl    (rs2_data_ppl),
    .imm_ppl         (imm_ppl),
    .rs1_ppl         (rs1_ppl),
    .rs2_ppl         (rs2_ppl),
    .rd_ppl          (rd_ppl),
    .alu_op_ppl      (alu_op_ppl),
    .alu_src_imm_ppl (alu_src_imm_ppl),
    .alu_src_pc_ppl  (alu_src_pc_ppl),
    .mem_read_ppl    (mem_read_ppl),
    .mem_write_ppl   (mem_write_ppl),
    .mem_funct3_ppl  (mem_funct3_ppl),
    .reg_write_ppl   (reg_write_ppl),
    .wb_sel_ppl      (wb_sel_ppl),
    .branch_ppl      (branch_ppl),
    .jal_ppl         (jal_ppl),
    .jalr_ppl        (jalr_ppl),
    .compressed_ppl  (compressed_ppl),
    .illegal_ppl     (illegal_ppl)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset with random inputs on every port.
    rst_n = 1'b0;
    stall = 1'($urandom); flush = 1'($urandom); compressed_i = 1'($urandom);
    inst_i = $urandom; pc_i = $urandom; wb_wen = 1'b1; wb_rd = 5'd3; wb_data = $urandom;
    ex_mem_read = 1'($urandom); ex_rd = 5'($urandom);
    repeat (2) step();
    chk("rst_pc",        pc_ppl, RST_PC);
    chk("rst_reg_write", 32'(reg_write_ppl), 32'd0);
    chk("rst_imm",       imm_ppl, 32'd0);
    chk("rst_rd",        32'(rd_ppl), 32'd0);
    chk("rst_alu_imm",   32'(alu_src_imm_ppl), 32'd0);

    // Release; first capture at the next edge.
    rst_n = 1'b1; stall = 1'b0; flush = 1'b0; compressed_i = 1'b0;
    wb_wen = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    inst_i = 32'h0050_0093; pc_i = 32'h100;
    #1;
    chk("pre_edge_pc", pc_ppl, RST_PC);
    step();
    chk("addi_imm",     imm_ppl, 32'd5);
    chk("addi_rd",      32'(rd_ppl), 32'd1);
    chk("addi_alu_imm", 32'(alu_src_imm_ppl), 32'd1);
    chk("addi_rw",      32'(reg_write_ppl), 32'd1);
    chk("addi_pc",      pc_ppl, 32'h100);
    chk("addi_aluop",   32'(alu_op_ppl), 32'd0);

    // x3 written in the same cycle add x2,x3,x0 reads it.
    wb_wen = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEAD_BEEF;
    inst_i = 32'h0001_8133; pc_i = 32'h104;
    step();
    chk("bypass_rs1", rs1_data_ppl, 32'hDEAD_BEEF);
    chk("bypass_rs2", rs2_data_ppl, 32'd0);
    chk("add_rd",     32'(rd_ppl), 32'd2);
    chk("add_aluimm", 32'(alu_src_imm_ppl), 32'd0);
    wb_wen = 1'b0;
    step();
    chk("stored_rs1", rs1_data_ppl, 32'hDEAD_BEEF);

    // Load-use on add x4,x5,x5.
    ex_mem_read = 1'b1; ex_rd = 5'd5; inst_i = 32'h0052_8233; pc_i = 32'h108;
    #1;
    chk("hazard_on", 32'(load_use_hazard), 32'd1);
    step();
    chk("bubble_rw",  32'(reg_write_ppl), 32'd0);
    chk("bubble_rd",  32'(rd_ppl), 32'd0);
    chk("bubble_pc",  pc_ppl, 32'h108);
    chk("bubble_rs1", 32'(rs1_ppl), 32'd0);
    ex_mem_read = 1'b0;
    #1;
    chk("hazard_clear", 32'(load_use_hazard), 32'd0);
    step();
    chk("reissue_rd",  32'(rd_ppl), 32'd4);
    chk("reissue_rs2", 32'(rs2_ppl), 32'd5);
    chk("reissue_rw",  32'(reg_write_ppl), 32'd1);

    ex_mem_read = 1'b1; ex_rd = 5'd0;
    #1;
    chk("hazard_rd0", 32'(load_use_hazard), 32'd0);
    ex_rd = 5'd5; inst_i = 32'h0050_02B7;
    #1;
    chk("hazard_lui", 32'(load_use_hazard), 32'd0);
    step();
    chk("lui_imm", imm_ppl, 32'h0050_0000);
    chk("lui_rd",  32'(rd_ppl), 32'd5);
    inst_i = 32'h0052_8233; flush = 1'b1;
    #1;
    chk("hazard_flush", 32'(load_use_hazard), 32'd0);
    ex_mem_read = 1'b0;

    // Flush with beq x1,x2,8 at the input.
    inst_i = 32'h0020_8463; pc_i = 32'h200;
    step();
    chk("flush_branch", 32'(branch_ppl), 32'd0);
    chk("flush_rw",     32'(reg_write_ppl), 32'd0);
    chk("flush_pc",     pc_ppl, 32'h200);
    flush = 1'b0;
    step();
    chk("beq_branch", 32'(branch_ppl), 32'd1);
    chk("beq_imm",    imm_ppl, 32'd8);
    chk("beq_aluop",  32'(alu_op_ppl), 32'd1);
    chk("beq_rw",     32'(reg_write_ppl), 32'd0);

    // stall + flush: nothing moves, and the write-back is blocked.
    stall = 1'b1; flush = 1'b1; inst_i = 32'h0050_0093; pc_i = 32'h300;
    wb_wen = 1'b1; wb_rd = 5'd6; wb_data = 32'h55;
    step();
    chk("stall_pc",     pc_ppl, 32'h200);
    chk("stall_branch", 32'(branch_ppl), 32'd1);
    chk("stall_imm",    imm_ppl, 32'd8);
    stall = 1'b0; flush = 1'b0; wb_wen = 1'b0;
    inst_i = 32'h0003_03B3; pc_i = 32'h304;
    step();
    chk("stall_no_write", rs1_data_ppl, 32'd0);
    chk("add_x7_rd",      32'(rd_ppl), 32'd7);

    // c.li x10,5 with junk in the upper half.
    compressed_i = 1'b1; inst_i = 32'hABCD_4515; pc_i = 32'h400;
    step();
    chk("cli_rd",   32'(rd_ppl), 32'd10);
    chk("cli_imm",  imm_ppl, 32'd5);
    chk("cli_comp", 32'(compressed_ppl), 32'd1);
    chk("cli_rw",   32'(reg_write_ppl), 32'd1);
    compressed_i = 1'b0;

    // Undefined opcode.
    inst_i = 32'h0000_007F;
    step();
    chk("ill_flag", 32'(illegal_ppl), 32'd1);
    chk("ill_side", {27'd0, reg_write_ppl, mem_read_ppl, mem_write_ppl, branch_ppl, jal_ppl | jalr_ppl}, 32'd0);

    // sw x5,12(x1) and jal x1,-4.
    inst_i = 32'h0050_A623;
    step();
    chk("sw_imm",  imm_ppl, 32'd12);
    chk("sw_ctl",  {28'd0, mem_write_ppl, mem_funct3_ppl}, 32'hA);
    chk("sw_rw",   32'(reg_write_ppl), 32'd0);
    inst_i = 32'hFFDF_F0EF;
    step();
    chk("jal_imm",  imm_ppl, 32'hFFFF_FFFC);
    chk("jal_ctl",  {28'd0, jal_ppl, reg_write_ppl, wb_sel_ppl}, 32'hE);
    chk("jal_rd",   32'(rd_ppl), 32'd1);

    // Asynchronous reset mid-operation; hazard still combinational.
    ex_mem_read = 1'b1; ex_rd = 5'd5; inst_i = 32'h0052_8233;
    rst_n = 1'b0;
    #1;
    chk("async_pc",  pc_ppl, RST_PC);
    chk("async_rw",  32'(reg_write_ppl), 32'd0);
    chk("async_imm", imm_ppl, 32'd0);
    chk("async_haz", 32'(load_use_hazard), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
